wptr_handler: RTL and testbench

Write-domain pointer handler for the asynchronous FIFO, the counterpart of the read pointer handler. It accepts write requests in the `w_clk` domain and maintains the binary write pointer (memory address) and the Gray write pointer (exported to the read domain). It synchronizes the read-domain Gray pointer into `w_clk` and derives `full`, `almost_full`, the fill level and a sticky overflow error from it.

---
 rtl/async_fifo_pkg.sv | 28 ++
 rtl/ptr_sync.sv | 29 ++
 rtl/wptr_handler.sv | 80 ++++++++
 tb/tb_wptr_handler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer handlers:
// default pointer width, depth derivation and Gray/binary conversion.
package async_fifo_pkg;

    localparam int unsigned PTR_WIDTH_DEF = 4;
    localparam int unsigned GRAY_MAX_W    = 32;

    // Depth excludes the wrap bit of the pointer
    function automatic int unsigned depth_of(input int unsigned ptr_width);
        return 32'(1) << (ptr_width - 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB down; zero-extended inputs convert correctly
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_handler.sv
// Write-domain pointer handler: binary/Gray write pointers, synchronized read
// pointer, and pessimistic full / almost_full / level / sticky overflow flags.
module wptr_handler
    import async_fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_en,
    input  logic [PTR_WIDTH-1:0] g_rptr,
    output logic [PTR_WIDTH-1:0] b_wptr,
    output logic [PTR_WIDTH-1:0] g_wptr,
    output logic [PTR_WIDTH-2:0] w_addr,
    output logic                 w_inc,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH-1:0] w_level,
    output logic                 overflow
);

    localparam int unsigned DEPTH = depth_of(PTR_WIDTH);
    // Threshold clamped to DEPTH so an out-of-range setting degrades to full
    localparam logic [PTR_WIDTH-1:0] AFULL_LVL =
        PTR_WIDTH'((AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH);

    logic [PTR_WIDTH-1:0] g_rsync;
    logic [PTR_WIDTH-1:0] b_rsync;
    logic [PTR_WIDTH-1:0] b_next;
    logic [PTR_WIDTH-1:0] g_next;
    logic [PTR_WIDTH-1:0] level_next;
    logic                 full_next;
    logic                 afull_next;

    ptr_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .d     (g_rptr),
        .q     (g_rsync)
    );

    assign w_inc  = w_en & ~full;
    assign w_addr = b_wptr[PTR_WIDTH-2:0];

    // Next-state pointers and flags; flags see this cycle's write immediately
    always_comb begin
        b_rsync    = PTR_WIDTH'(gray2bin(GRAY_MAX_W'(g_rsync)));
        b_next     = b_wptr + PTR_WIDTH'(w_inc);
        g_next     = PTR_WIDTH'(bin2gray(GRAY_MAX_W'(b_next)));
        full_next  = (g_next == {~g_rsync[PTR_WIDTH-1 -: 2], g_rsync[PTR_WIDTH-3:0]});
        level_next = b_next - b_rsync;
        afull_next = (level_next >= AFULL_LVL);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            full        <= full_next;
            almost_full <= afull_next;
            w_level     <= level_next;
            if (w_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wptr_handler.sv
// Self-checking bench for wptr_handler against a count-based reference model.
module tb_wptr_handler;

    logic       w_clk   = 1'b0;
    logic       w_rst_n = 1'b1;
    logic       w_en    = 1'b0;
    logic [3:0] g_rptr  = 4'd0;
    logic [3:0] b_wptr;
    logic [3:0] g_wptr;
    logic [2:0] w_addr;
    logic       w_inc;
    logic       full;
    logic       almost_full;
    logic [3:0] w_level;
    logic       overflow;

    wptr_handler #(
        .PTR_WIDTH    (4),
        .AFULL_THRESH (6),
        .SYNC_STAGES  (2)
    ) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_en        (w_en),
        .g_rptr      (g_rptr),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .w_addr      (w_addr),
        .w_inc       (w_inc),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: write count, read pointer seen two edges late
    int m_bw;
    int m_level;
    bit m_full;
    bit m_af;
    bit m_ovf;
    int rq[$];

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int gray_rank(input int g);
        for (int i = 0; i < 16; i++) begin
            if (gray_of(i) == g) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_bw    = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_af    = 1'b0;
        m_ovf   = 1'b0;
        rq      = '{0, 0};
    endfunction

    function automatic void model_step();
        int rb;
        if (w_en && m_full) m_ovf = 1'b1;
        if (w_en && !m_full) m_bw = (m_bw + 1) % 16;
        rb = gray_rank(rq.pop_front());
        rq.push_back(int'(g_rptr));
        m_level = (m_bw - rb + 16) % 16;
        m_full  = (m_level == 8);
        m_af    = (m_level >= 6);
    endfunction

    task automatic tick();
        @(posedge w_clk);
        if (w_rst_n) model_step();
        #1;
    endtask

    task automatic reset_pulse();
        w_en    = 1'b0;
        g_rptr  = 4'd0;
        w_rst_n = 1'b0;
        model_reset();
        #1;
        w_rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_b_wptr"}, int'(b_wptr), 0);
        chk({tag, "_g_wptr"}, int'(g_wptr), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_afull"}, int'(almost_full), 0);
        chk({tag, "_level"}, int'(w_level), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge w_clk) begin
        if (cmp_en) begin
            chk("b_wptr", int'(b_wptr), m_bw);
            chk("g_wptr", int'(g_wptr), gray_of(m_bw));
            chk("w_addr", int'(w_addr), m_bw % 8);
            chk("w_inc", int'(w_inc), int'(w_en && !m_full));
            chk("full", int'(full), int'(m_full));
            chk("almost_full", int'(almost_full), int'(m_af));
            chk("w_level", int'(w_level), m_level);
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    initial begin
        logic [3:0] gseq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        logic [3:0] prev_g;
        logic [3:0] prev_b;
        bit         saw_wrap;
        int         wh[$];
        int         rb;

        #1;
        w_rst_n = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (2) tick();
        w_rst_n = 1'b1;

        // Reset asserted mid-cycle while writing
        w_en = 1'b1;
        repeat (3) tick();
        chk("pre_reset_b_wptr", int'(b_wptr), 3);
        #2;
        w_rst_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rst_async");
        tick();
        w_en    = 1'b0;
        w_rst_n = 1'b1;
        tick();
        chk_all_zero("rst_release");

        // Fill to full with the reader idle
        g_rptr = 4'd0;
        w_en   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("fill_b_wptr", int'(b_wptr), i);
            chk("fill_g_wptr", int'(g_wptr), int'(gseq[i-1]));
            chk("fill_afull", int'(almost_full), int'(i >= 6));
            chk("fill_full", int'(full), int'(i == 8));
            chk("fill_level", int'(w_level), i);
        end

        // Writes while full are blocked and latch overflow
        repeat (3) begin
            chk("ovf_w_inc", int'(w_inc), 0);
            tick();
            chk("ovf_b_wptr", int'(b_wptr), 8);
            chk("ovf_flag", int'(overflow), 1);
        end
        w_en = 1'b0;
        tick();
        chk("ovf_sticky", int'(overflow), 1);

        // Drain one entry: flags lag by the synchronizer
        g_rptr = 4'b0001;
        tick();
        tick();
        chk("drain_k1_full", int'(full), 1);
        chk("drain_k1_level", int'(w_level), 8);
        tick();
        chk("drain_k2_full", int'(full), 0);
        chk("drain_k2_level", int'(w_level), 7);
        w_en = 1'b1;
        tick();
        chk("drain_k3_full", int'(full), 1);
        chk("drain_k3_b_wptr", int'(b_wptr), 9);
        w_en = 1'b0;

        // Wrap-around with a reader trailing three cycles behind
        reset_pulse();
        wh       = '{0, 0, 0};
        prev_g   = 4'd0;
        prev_b   = 4'd0;
        saw_wrap = 1'b0;
        w_en     = 1'b1;
        repeat (40) begin
            tick();
            chk("wrap_full", int'(full), 0);
            chk("wrap_gray_step", $countones(g_wptr ^ prev_g), 1);
            if (prev_b == 4'd15 && b_wptr == 4'd0 && prev_g == 4'b1000 && g_wptr == 4'd0)
                saw_wrap = 1'b1;
            prev_b = b_wptr;
            prev_g = g_wptr;
            wh.push_back(m_bw);
            g_rptr = 4'(gray_of(wh.pop_front()));
        end
        chk("wrap_seen", int'(saw_wrap), 1);

        // Randomized writer and reader
        reset_pulse();
        rb = 0;
        repeat (400) begin
            w_en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1 && rb != m_bw) rb = (rb + 1) % 16;
            g_rptr = 4'(gray_of(rb));
            tick();
        end

        // Reset in the middle of operation clears the sticky overflow
        reset_pulse();
        w_en = 1'b1;
        repeat (9) tick();
        chk("mid_ovf_set", int'(overflow), 1);
        w_en   = 1'b0;
        g_rptr = 4'(gray_of(3));
        repeat (3) tick();
        chk("mid_level", int'(w_level), 5);
        chk("mid_full", int'(full), 0);
        w_rst_n = 1'b0;
        model_reset();
        g_rptr = 4'd0;
        #1;
        w_rst_n = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) tick();
        chk("post_rst_level", int'(w_level), 0);

        cmp_en = 1'b0;
        @(negedge w_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
